// File: rtl/ocx_tlx_pkg.sv
// Shared types for the TLX VC0 response path: scheduler states and FIFO data width.
package ocx_tlx_pkg;

  localparam int RESP_FIFO_DATA_W = 56;

  typedef enum logic [1:0] {
    INIT_LOAD,
    INIT_CRED,
    RUN
  } rd_sched_state_t;

endpackage

// File: rtl/ocx_tlx_credit_cnt.sv
// Up/down credit counter with load. Simultaneous inc and dec leaves the count unchanged.
// The count saturates at both ends.
module ocx_tlx_credit_cnt #(
  parameter int WIDTH = 7
) (
  input  logic             tlx_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ocx_tlx_resp_rd_sched.sv
// Pointer, commit and credit controller for the TLX->AFU VC0 response info FIFO.
// The BRAM itself lives in the parent; this block drives its addresses and enables.
module ocx_tlx_resp_rd_sched
  import ocx_tlx_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int CREDIT_WIDTH = 7
) (
  input  logic                    tlx_clk,
  input  logic                    reset_n,
  input  logic                    parse_wr_ena,
  input  logic                    control_parsing_end,
  input  logic                    crc_error,
  input  logic                    data_hold_vc0,
  input  logic [CREDIT_WIDTH-1:0] afu_tlx_resp_initial_credit,
  input  logic                    afu_tlx_resp_credit,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    rd_ena,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    tlx_afu_valid,
  output logic                    rcv_xmt_credit_v,
  output logic                    fifo_overflow,
  output logic                    credit_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  rd_sched_state_t         state;
  rd_sched_state_t         state_nxt;
  logic [PW-1:0]           wptr_spec;
  logic [PW-1:0]           wptr_cmt;
  logic [PW-1:0]           rptr;
  logic [PW-1:0]           init_cnt;
  logic [PW-1:0]           occupancy;
  logic [PW-1:0]           wptr_inc;
  logic [PW-1:0]           pend_cnt;
  logic [CREDIT_WIDTH-1:0] afu_cnt;
  logic                    full;
  logic                    wr_accept;
  logic                    read_ready;

  assign occupancy  = wptr_spec - rptr;
  assign full       = (occupancy == DEPTH);
  assign wr_accept  = parse_wr_ena && !full;
  assign wptr_inc   = wptr_spec + PW'(wr_accept);
  assign read_ready = (wptr_cmt != rptr) && (afu_cnt != '0) && !data_hold_vc0;
  assign wr_addr    = wptr_spec[ADDR_WIDTH-1:0];
  assign rd_addr    = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Credits freed by reads during the init burst are deferred and drained in RUN.
  always_comb begin
    state_nxt        = state;
    rd_ena           = 1'b0;
    rcv_xmt_credit_v = 1'b0;
    case (state)
      INIT_LOAD: state_nxt = INIT_CRED;
      INIT_CRED: begin
        rd_ena           = read_ready;
        rcv_xmt_credit_v = 1'b1;
        if (init_cnt == PW'(1)) state_nxt = RUN;
      end
      RUN: begin
        rd_ena           = read_ready;
        rcv_xmt_credit_v = read_ready || (pend_cnt != '0);
      end
      default: state_nxt = INIT_LOAD;
    endcase
  end

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt <= '0;
    end else if (state == INIT_LOAD) begin
      init_cnt <= DEPTH;
    end else if (state == INIT_CRED) begin
      init_cnt <= init_cnt - 1'b1;
    end
  end

  // A rollback restores the speculative pointer and drops any same-cycle write.
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_spec       <= '0;
      wptr_cmt        <= '0;
      rptr            <= '0;
      tlx_afu_valid   <= 1'b0;
      fifo_overflow   <= 1'b0;
      credit_overflow <= 1'b0;
    end else begin
      if (crc_error) begin
        wptr_spec <= wptr_cmt;
      end else begin
        wptr_spec <= wptr_inc;
        if (control_parsing_end) wptr_cmt <= wptr_inc;
      end
      if (rd_ena) rptr <= rptr + 1'b1;
      tlx_afu_valid <= rd_ena;
      if (parse_wr_ena && full) fifo_overflow <= 1'b1;
      if (afu_tlx_resp_credit && !rd_ena && (afu_cnt == '1) && (state != INIT_LOAD))
        credit_overflow <= 1'b1;
    end
  end

  ocx_tlx_credit_cnt #(.WIDTH(CREDIT_WIDTH)) u_afu_cnt (
    .tlx_clk  (tlx_clk),
    .reset_n  (reset_n),
    .load     (state == INIT_LOAD),
    .load_val (afu_tlx_resp_initial_credit),
    .inc      (afu_tlx_resp_credit),
    .dec      (rd_ena),
    .cnt      (afu_cnt)
  );

  ocx_tlx_credit_cnt #(.WIDTH(PW)) u_pend_cnt (
    .tlx_clk  (tlx_clk),
    .reset_n  (reset_n),
    .load     (state == INIT_LOAD),
    .load_val ('0),
    .inc      (rd_ena),
    .dec      ((state == RUN) && rcv_xmt_credit_v),
    .cnt      (pend_cnt)
  );

endmodule

// File: tb/tb_ocx_tlx_resp_rd_sched.sv
// Directed bench for ocx_tlx_resp_rd_sched with a count-based reference model checked every cycle.
module tb_ocx_tlx_resp_rd_sched;

  localparam int AW          = 7;
  localparam int CW          = 7;
  localparam int DEPTH       = 128;
  localparam int CMAX        = 127;
  localparam int INIT_CREDIT = 4;

  logic          tlx_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          parse_wr_ena = 1'b0;
  logic          control_parsing_end = 1'b0;
  logic          crc_error = 1'b0;
  logic          data_hold_vc0 = 1'b0;
  logic [CW-1:0] afu_tlx_resp_initial_credit = CW'(INIT_CREDIT);
  logic          afu_tlx_resp_credit = 1'b0;
  logic [AW-1:0] wr_addr;
  logic          rd_ena;
  logic [AW-1:0] rd_addr;
  logic          tlx_afu_valid;
  logic          rcv_xmt_credit_v;
  logic          fifo_overflow;
  logic          credit_overflow;

  int n_cmp = 0;
  int n_fail = 0;
  int credit_pulses = 0;
  int read_count = 0;

  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_resp_rd_sched #(.ADDR_WIDTH(AW), .CREDIT_WIDTH(CW)) dut (
    .tlx_clk                     (tlx_clk),
    .reset_n                     (reset_n),
    .parse_wr_ena                (parse_wr_ena),
    .control_parsing_end         (control_parsing_end),
    .crc_error                   (crc_error),
    .data_hold_vc0               (data_hold_vc0),
    .afu_tlx_resp_initial_credit (afu_tlx_resp_initial_credit),
    .afu_tlx_resp_credit         (afu_tlx_resp_credit),
    .wr_addr                     (wr_addr),
    .rd_ena                      (rd_ena),
    .rd_addr                     (rd_addr),
    .tlx_afu_valid               (tlx_afu_valid),
    .rcv_xmt_credit_v            (rcv_xmt_credit_v),
    .fifo_overflow               (fifo_overflow),
    .credit_overflow             (credit_overflow)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; return at the following falling edge.
  task automatic applyStimulus(input logic wr, input logic cmt, input logic crc,
                               input logic hold, input logic cred);
    @(posedge tlx_clk);
    #1;
    parse_wr_ena        = wr;
    control_parsing_end = cmt;
    crc_error           = crc;
    data_hold_vc0       = hold;
    afu_tlx_resp_credit = cred;
    @(negedge tlx_clk);
    if (rcv_xmt_credit_v) credit_pulses++;
    if (rd_ena) read_count++;
  endtask

  // Reference model: unbounded entry counts plus credit conservation (owed = DEPTH + reads).
  int m_since = 0, m_wspec = 0, m_wcmt = 0, m_rd = 0, m_afu = 0, m_emitted = 0;
  bit m_valid = 0, m_fovf = 0, m_covf = 0;

  always begin : model_cmp
    bit e_rd, e_cred, in_load, in_cred, full;
    @(negedge tlx_clk);
    in_load = (m_since == 0);
    in_cred = (m_since >= 1) && (m_since <= DEPTH);
    e_rd    = !in_load && (m_wcmt != m_rd) && (m_afu > 0) && !data_hold_vc0;
    if (in_load)      e_cred = 1'b0;
    else if (in_cred) e_cred = 1'b1;
    else              e_cred = (DEPTH + m_rd + int'(e_rd)) > m_emitted;
    checkOutput("cyc_rd_ena", rd_ena, e_rd);
    checkOutput("cyc_rd_addr", rd_addr, m_rd % DEPTH);
    checkOutput("cyc_wr_addr", wr_addr, m_wspec % DEPTH);
    checkOutput("cyc_valid", tlx_afu_valid, m_valid);
    checkOutput("cyc_credit", rcv_xmt_credit_v, e_cred);
    checkOutput("cyc_fifo_ovf", fifo_overflow, m_fovf);
    checkOutput("cyc_credit_ovf", credit_overflow, m_covf);
    @(posedge tlx_clk);
    if (!reset_n) begin
      m_since = 0; m_wspec = 0; m_wcmt = 0; m_rd = 0; m_afu = 0; m_emitted = 0;
      m_valid = 0; m_fovf = 0; m_covf = 0;
    end else begin
      full = ((m_wspec - m_rd) == DEPTH);
      if (parse_wr_ena && full) m_fovf = 1;
      if (crc_error) m_wspec = m_wcmt;
      else begin
        if (parse_wr_ena && !full) m_wspec++;
        if (control_parsing_end) m_wcmt = m_wspec;
      end
      if (e_rd) m_rd++;
      if (in_load) m_afu = int'(afu_tlx_resp_initial_credit);
      else if (afu_tlx_resp_credit && !e_rd) begin
        if (m_afu == CMAX) m_covf = 1;
        else m_afu++;
      end else if (e_rd && !afu_tlx_resp_credit) m_afu--;
      if (e_cred) m_emitted++;
      m_valid = e_rd;
      if (m_since <= DEPTH) m_since++;
    end
  end

  initial begin
    int first_k, last_k;

    // Reset state
    #1;
    checkOutput("rst_rd_ena", rd_ena, 0);
    checkOutput("rst_credit", rcv_xmt_credit_v, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_valid", tlx_afu_valid, 0);
    repeat (2) @(posedge tlx_clk);
    #1;
    reset_n = 1'b1;

    // Init burst: edge 1 after release leaves INIT_LOAD, pulses on edges 1..128
    credit_pulses = 0;
    first_k = -1;
    last_k  = -1;
    for (int k = 1; k <= 135; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (rcv_xmt_credit_v) begin
        if (first_k < 0) first_k = k;
        last_k = k;
      end
    end
    checkOutput("init_pulses", credit_pulses, DEPTH);
    checkOutput("init_first", first_k, 1);
    checkOutput("init_last", last_k, DEPTH);

    // Three committed entries read back-to-back
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_wr_addr0", wr_addr, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("t2_no_early_read", rd_ena, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_rd_ena", rd_ena, 1);
      checkOutput("t2_rd_addr", rd_addr, i);
      checkOutput("t2_valid", tlx_afu_valid, int'(i > 0));
      checkOutput("t2_credit", rcv_xmt_credit_v, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_rd_done", rd_ena, 0);
    checkOutput("t2_valid_tail", tlx_afu_valid, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_valid_off", tlx_afu_valid, 0);

    // Rollback: crc_error beats control_parsing_end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3_wr_addr", wr_addr, 3);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_no_read", rd_ena, 0);
    checkOutput("t3_wr_rewind", wr_addr, 3);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_read_new", rd_ena, 1);
    checkOutput("t3_read_addr", rd_addr, 3);

    // Credit starvation: afu_cnt is now 0
    for (int i = 0; i < 5; i++) applyStimulus(1, i == 4, 0, 0, 0);
    repeat (2) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t4_no_credit", rd_ena, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_credit_cycle", rd_ena, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_one_read", rd_ena, 1);
    checkOutput("t4_one_addr", rd_addr, 4);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_single_read", rd_ena, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_sim_read", rd_ena, 1);
    checkOutput("t4_sim_addr", rd_addr, 5);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_cnt_kept", rd_ena, 1);
    checkOutput("t4_kept_addr", rd_addr, 6);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_cnt_empty", rd_ena, 0);

    // Fill to 128 (2 already held), overflow, then drain across the wrap
    for (int i = 0; i < 126; i++) begin
      applyStimulus(1, i == 125, 0, 0, 0);
      if (i == 118) checkOutput("t5_wr_127", wr_addr, 127);
      if (i == 119) checkOutput("t5_wr_wrap", wr_addr, 0);
    end
    checkOutput("t5_ovf_before", fifo_overflow, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_ovf_set", fifo_overflow, 1);
    checkOutput("t5_wr_hold", wr_addr, 7);
    applyStimulus(0, 0, 0, 0, 1);
    read_count = 0;
    for (int j = 0; j < DEPTH; j++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (j == 120) checkOutput("t5_rd_127", rd_addr, 127);
      if (j == 121) checkOutput("t5_rd_wrap", rd_addr, 0);
    end
    checkOutput("t5_drain_count", read_count, DEPTH);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_empty", rd_ena, 0);
    checkOutput("t5_rd_end", rd_addr, 7);
    checkOutput("t5_wr_end", wr_addr, 7);

    // afu_cnt is 1; push to max then one more return
    repeat (126) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_covf_before", credit_overflow, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_covf_set", credit_overflow, 1);

    // Reset mid-burst, then re-init with reads during the init burst
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_burst_valid", tlx_afu_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_rd", rd_ena, 0);
    checkOutput("t6_async_valid", tlx_afu_valid, 0);
    checkOutput("t6_async_credit", rcv_xmt_credit_v, 0);
    checkOutput("t6_async_wr", wr_addr, 0);
    checkOutput("t6_async_rdaddr", rd_addr, 0);
    checkOutput("t6_async_fovf", fifo_overflow, 0);
    checkOutput("t6_async_covf", credit_overflow, 0);
    repeat (2) @(posedge tlx_clk);
    #1;
    reset_n = 1'b1;
    credit_pulses = 0;
    read_count = 0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6_hold", rd_ena, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6_hold2", rd_ena, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_hold_release", rd_ena, 1);
    checkOutput("t6_hold_addr", rd_addr, 0);
    repeat (140) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_total_credits", credit_pulses, DEPTH + 3);
    checkOutput("t6_reads", read_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
